// File: rtl/rmt_pkg.sv
// rmt_pkg: header offsets, match constants and FSM encodings shared by the
// rmt classifier and the rmt_merge return path.
package rmt_pkg;

    // Byte offsets into the first beat (byte n = tdata[8n+:8])
    localparam int ETH_DST  = 0;
    localparam int ETH_SRC  = 6;
    localparam int ETH_TYPE = 12;
    localparam int TAG      = 42;
    localparam int FUNC     = 44;

    // Header fields as they appear on the little-endian byte bus
    localparam logic [15:0] ETHERTYPE_IPV4_BUS = 16'h0008;
    localparam logic [15:0] RMT_TAG            = 16'hF0E1;

    // Merge FSM encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    // A frame carries an rmt tag only when it is IPv4 and holds the magic tag
    function automatic logic isRmtTagged(input logic [15:0] etherType,
                                         input logic [15:0] tagField);
        return (etherType == ETHERTYPE_IPV4_BUS) && (tagField == RMT_TAG);
    endfunction

endpackage

// File: rtl/rmt_axis_skid.sv
// rmt_axis_skid: two-entry AXI-Stream register slice. The upstream ready is a
// pure register output, so downstream ready never reaches the input side
// combinationally, while a second entry keeps full throughput.
module rmt_axis_skid #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 8,
    parameter int ID_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic [KEEP_WIDTH-1:0] i_tkeep,
    input  logic                  i_tvalid,
    output logic                  o_tready,
    input  logic                  i_tlast,
    input  logic [USER_WIDTH-1:0] i_tuser,
    input  logic [ID_WIDTH-1:0]   i_tid,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic [KEEP_WIDTH-1:0] o_tkeep,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_tlast,
    output logic [USER_WIDTH-1:0] o_tuser,
    output logic [ID_WIDTH-1:0]   o_tid
);

    localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH + ID_WIDTH;

    logic [PW-1:0] w_inPayload;
    logic          w_inFire;
    logic          w_outFree;
    logic [PW-1:0] r_outPayload;
    logic          r_outValid;
    logic [PW-1:0] r_skidPayload;
    logic          r_skidValid;

    assign w_inPayload = {i_tdata, i_tkeep, i_tlast, i_tuser, i_tid};
    assign o_tready    = ~r_skidValid;
    assign w_inFire    = i_tvalid & ~r_skidValid;
    assign w_outFree   = ~r_outValid | i_tready;

    assign {o_tdata, o_tkeep, o_tlast, o_tuser, o_tid} = r_outPayload;
    assign o_tvalid = r_outValid;

    // Output register refills from the skid entry first, otherwise straight
    // from the input; the skid entry only catches a beat during a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outPayload  <= '0;
            r_outValid    <= 1'b0;
            r_skidPayload <= '0;
            r_skidValid   <= 1'b0;
        end else if (w_outFree) begin
            if (r_skidValid) begin
                r_outPayload <= r_skidPayload;
                r_outValid   <= 1'b1;
                r_skidValid  <= 1'b0;
            end else begin
                r_outValid <= w_inFire;
                if (w_inFire) begin
                    r_outPayload <= w_inPayload;
                end
            end
        end else if (w_inFire) begin
            r_skidPayload <= w_inPayload;
            r_skidValid   <= 1'b1;
        end
    end

endmodule

// File: rtl/rmt_merge.sv
// rmt_merge: packet-level round-robin merge of the function-engine reply
// streams. Tagged replies get their MAC addresses swapped and the source
// port written into the function field so they return to the requester.
module rmt_merge
    import rmt_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 8,
    parameter int PORT_COUNT = 2,
    parameter int ID_WIDTH   = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORT_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [PORT_COUNT-1:0]            s_axis_tvalid,
    output logic [PORT_COUNT-1:0]            s_axis_tready,
    input  logic [PORT_COUNT-1:0]            s_axis_tlast,
    input  logic [PORT_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    output logic [31:0]                      stat_pkt_tagged,
    output logic [31:0]                      stat_pkt_raw
);

    logic [0:0]            r_state;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic                  r_firstBeat;
    logic                  r_tagged;
    logic [31:0]           r_statTagged;
    logic [31:0]           r_statRaw;

    logic [DATA_WIDTH-1:0] w_selData;
    logic [KEEP_WIDTH-1:0] w_selKeep;
    logic                  w_selValid;
    logic                  w_selLast;
    logic [USER_WIDTH-1:0] w_selUser;
    logic                  w_anyValid;
    logic [ID_WIDTH-1:0]   w_nextGrant;
    logic                  w_xfer;
    logic                  w_skidReady;
    logic                  w_accept;
    logic                  w_hdrTagged;
    logic                  w_pktTagged;
    logic [DATA_WIDTH-1:0] w_outData;

    assign w_xfer      = (r_state == ST_XFER);
    assign w_accept    = w_xfer & w_selValid & w_skidReady;
    assign w_hdrTagged = isRmtTagged(w_selData[ETH_TYPE*8 +: 16], w_selData[TAG*8 +: 16]);
    assign w_pktTagged = r_firstBeat ? w_hdrTagged : r_tagged;

    assign stat_pkt_tagged = r_statTagged;
    assign stat_pkt_raw    = r_statRaw;

    // Route the granted port's beat towards the output stage
    always_comb begin
        w_selData  = '0;
        w_selKeep  = '0;
        w_selValid = 1'b0;
        w_selLast  = 1'b0;
        w_selUser  = '0;
        for (int p = 0; p < PORT_COUNT; p++) begin
            if (r_grant == ID_WIDTH'(p)) begin
                w_selData  = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                w_selKeep  = s_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
                w_selValid = s_axis_tvalid[p];
                w_selLast  = s_axis_tlast[p];
                w_selUser  = s_axis_tuser[p*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    // Only the granted port sees ready, and only while the output stage has room
    always_comb begin
        s_axis_tready = '0;
        for (int p = 0; p < PORT_COUNT; p++) begin
            if (w_xfer && (r_grant == ID_WIDTH'(p))) begin
                s_axis_tready[p] = w_skidReady;
            end
        end
    end

    // Round-robin search: first valid port at or after the pointer, with wrap;
    // scanning downward lets the closest candidate overwrite the others
    always_comb begin
        int idx;
        idx         = 0;
        w_anyValid  = 1'b0;
        w_nextGrant = r_ptr;
        for (int i = PORT_COUNT - 1; i >= 0; i--) begin
            idx = (int'(r_ptr) + i) % PORT_COUNT;
            if (s_axis_tvalid[idx]) begin
                w_anyValid  = 1'b1;
                w_nextGrant = ID_WIDTH'(idx);
            end
        end
    end

    // First beat of a tagged packet: swap MACs and stamp the source port
    always_comb begin
        w_outData = w_selData;
        if (r_firstBeat && w_hdrTagged) begin
            w_outData[ETH_DST*8 +: 48] = w_selData[ETH_SRC*8 +: 48];
            w_outData[ETH_SRC*8 +: 48] = w_selData[ETH_DST*8 +: 48];
            w_outData[FUNC*8 +: 16]    = 16'(r_grant);
        end
    end

    // Packet FSM: grant in IDLE, hold the grant through XFER until tlast
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_firstBeat <= 1'b0;
            r_tagged    <= 1'b0;
        end else if (!w_xfer) begin
            if (w_anyValid) begin
                r_grant     <= w_nextGrant;
                r_firstBeat <= 1'b1;
                r_state     <= ST_XFER;
            end
        end else if (w_accept) begin
            r_firstBeat <= 1'b0;
            if (r_firstBeat) begin
                r_tagged <= w_hdrTagged;
            end
            if (w_selLast) begin
                r_state <= ST_IDLE;
                r_ptr   <= (r_grant == ID_WIDTH'(PORT_COUNT - 1)) ? '0 : r_grant + 1'b1;
            end
        end
    end

    // Count each completed packet as tagged or raw when its tlast is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_statTagged <= '0;
            r_statRaw    <= '0;
        end else if (w_accept && w_selLast) begin
            if (w_pktTagged) begin
                r_statTagged <= r_statTagged + 32'd1;
            end else begin
                r_statRaw <= r_statRaw + 32'd1;
            end
        end
    end

    rmt_axis_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .USER_WIDTH (USER_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_tdata  (w_outData),
        .i_tkeep  (w_selKeep),
        .i_tvalid (w_xfer & w_selValid),
        .o_tready (w_skidReady),
        .i_tlast  (w_selLast),
        .i_tuser  (w_selUser),
        .i_tid    (r_grant),
        .o_tdata  (m_axis_tdata),
        .o_tkeep  (m_axis_tkeep),
        .o_tvalid (m_axis_tvalid),
        .i_tready (m_axis_tready),
        .o_tlast  (m_axis_tlast),
        .o_tuser  (m_axis_tuser),
        .o_tid    (m_axis_tid)
    );

endmodule

// File: doc/rmt_merge.md
Name: rmt_merge

Overview:
- Return-path companion to the rmt classifier: merges the response streams from PORT_COUNT function engines (one per classifier tdest value) into a single AXI-Stream toward the MAC TX path.
- Arbitration is packet-level round-robin.
- On the first beat of each tagged packet, the block swaps the Ethernet MAC addresses and writes the function tag, so the reply is addressed back to the requester.
- Sits between the function engines and the interface TX datapath in the app template.

Parameters:
- DATA_WIDTH, 512, AXIS data width in bits; must be at least 368 (46 header bytes).
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 8, tuser width; passed through unchanged.
- PORT_COUNT, 2, number of engine input streams; range 2..4.
- ID_WIDTH, 2, width of m_axis_tid; must be at least clog2(PORT_COUNT).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  PORT_COUNT*DATA_WIDTH  per-port data; port p occupies slice p
- s_axis_tkeep  in  PORT_COUNT*KEEP_WIDTH  per-port keep
- s_axis_tvalid  in  PORT_COUNT  per-port valid
- s_axis_tready  out  PORT_COUNT  per-port ready
- s_axis_tlast  in  PORT_COUNT  per-port last
- s_axis_tuser  in  PORT_COUNT*USER_WIDTH  per-port user
- m_axis_tdata  out  DATA_WIDTH  merged data
- m_axis_tkeep  out  KEEP_WIDTH  merged keep
- m_axis_tvalid  out  1  merged valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  merged last
- m_axis_tuser  out  USER_WIDTH  merged user
- m_axis_tid  out  ID_WIDTH  index of the source port of the current packet
- stat_pkt_tagged  out  32  count of packets rewritten
- stat_pkt_raw  out  32  count of packets passed through unmodified

Behaviour:
- Reset (rst_n low, asynchronous): all m_axis_* outputs 0, s_axis_tready all 0, both stat counters 0, state IDLE, round-robin pointer 0, skid buffer empty.
- Reset mid-packet: the partial packet is abandoned. Downstream may see a truncated packet with no tlast; this is accepted behaviour.

State machine (two states):
- IDLE: s_axis_tready all 0. If any s_axis_tvalid is set, grant the first valid port at or after the pointer, searching upward with wrap. Register the grant and go to XFER. This costs one bubble cycle per packet.
- XFER: s_axis_tready[grant] = skid-buffer-not-full; all other ports' ready = 0. A beat is accepted when valid and ready are both high.
- On an accepted beat with tlast: pointer becomes (grant+1) mod PORT_COUNT and the state returns to IDLE.
- A single-beat packet (tlast on the first beat) completes XFER in one beat.

First-beat rewrite (byte n = tdata[8n+:8]):
- The packet is tagged when bytes 12..13 read 16'h0008 (bus order) AND tdata[42*8+:16] == 16'hF0E1.
- If tagged:
  - swap bytes 0..5 with bytes 6..11;
  - set tdata[44*8+:16] = grant, zero-extended to 16 bits (port 1 gives 16'h0001);
  - increment stat_pkt_tagged on the tlast beat.
- If not tagged: data is forwarded unchanged and stat_pkt_raw increments on the tlast beat.
- tkeep, tuser and tlast pass unchanged on all beats; later beats are never modified.
- Counters wrap modulo 2^32.

Output stage (rmt_axis_skid):
- Two-entry skid register; accepted beat to m_axis_tvalid latency is 1 cycle.
- Full throughput under continuous m_axis_tready; no combinational path from m_axis_tready to s_axis_tready.
- m_axis_tid = grant, held for the whole packet.
- While m_axis_tvalid is high and m_axis_tready is low, all m_axis_* outputs must stay stable (AXIS rule).

Boundary cases:
- Ports that deassert valid mid-packet only insert gaps; the grant is held.
- Valid on a non-granted port never produces ready.
- If all ports are valid, service order is 0,1,…,PORT_COUNT-1,0.

Decomposition:
- Package rmt_pkg holds:
  - header offsets: ETH_DST=0, ETH_SRC=6, ETH_TYPE=12, TAG=42, FUNC=44;
  - constants ETHERTYPE_IPV4_BUS=16'h0008 and RMT_TAG=16'hF0E1;
  - state encodings.
- The classifier shares this package.
- One sub-module: rmt_axis_skid (generic AXIS skid register carrying data/keep/last/user/id).

Test Plan:
- Tagged single packet on port 1:
  - stimulus: 3 beats; first beat has dst MAC 02:00:00:00:00:01, src 02:00:00:00:00:02, bytes 12..13 = 08 00, tag E1 F0;
  - required: output dst=02:..:02, src=02:..:01, func field 16'h0001, m_axis_tid=1, stat_pkt_tagged=1, beats 2–3 bit-identical.
- Untagged frame (ethertype bytes 86 DD) on port 0 → forwarded unchanged, tid=0, stat_pkt_raw=1, stat_pkt_tagged=0.
- Ports 0 and 1 continuously valid with 4-beat packets → output alternates 0,1,0,1 with no beat interleaving within a packet; one bubble cycle between packets.
- Backpressure: m_axis_tready toggles 1010… during a 5-beat packet → no beat lost or duplicated, outputs stable while stalled, in-order delivery.
- Assert rst_n low during beat 2 of a 4-beat packet → m_axis_tvalid=0 and s_axis_tready=0 within the reset assertion; counters 0; the next packet after release is granted from port 0 and emitted correctly.
- Single-beat tagged packet (tlast on the first beat) from port 2 (PORT_COUNT=3) → func field 16'h0002, tlast=1, state returns to IDLE, pointer advances to 0.
